// File: rtl/cpu_commit_stbuf.sv
// Commit/memory stage: one instruction per cycle, ALU writeback, and an in-order store buffer drained to data memory.
// Loads hit the youngest matching buffer entry or go to memory over req/gnt/rvalid; the stage stalls while a load miss is outstanding.
module cpu_commit_stbuf #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int SB_DEPTH       = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_reg_write,
    input  logic                      in_mem_read,
    input  logic                      in_mem_write,
    input  logic [REG_ADDR_WIDTH-1:0] in_reg_dest,
    input  logic [DATA_WIDTH-1:0]     in_alu_result,
    input  logic [DATA_WIDTH-1:0]     in_store_data,
    output logic                      wb_valid,
    output logic                      wb_reg_write,
    output logic [REG_ADDR_WIDTH-1:0] wb_reg_dest,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic [REG_ADDR_WIDTH-1:0] fw_rd,
    output logic                      fw_reg_write,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      sb_empty
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD_REQ, LOAD_WAIT} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     sb_addr_q [SB_DEPTH];
    logic [DATA_WIDTH-1:0]     sb_data_q [SB_DEPTH];
    logic [PTR_W-1:0]          head_q, tail_q;
    logic [CNT_W-1:0]          count_q;
    logic                      rw_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [ADDR_WIDTH-1:0]     ld_addr_q;

    logic                      wb_valid_q, wb_valid_d;
    logic                      wb_reg_write_q, wb_reg_write_d;
    logic [REG_ADDR_WIDTH-1:0] wb_reg_dest_q, wb_reg_dest_d;
    logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;

    logic                      accept, push, pop, hit, sb_full;
    logic [DATA_WIDTH-1:0]     hit_data;
    logic [ADDR_WIDTH-1:0]     in_addr;

    assign in_addr  = in_alu_result[ADDR_WIDTH-1:0];
    assign sb_full  = (count_q == CNT_W'(SB_DEPTH));
    // Gated by reset so every output other than sb_empty reads 0 while reset is held.
    assign in_ready = reset && (state_q == IDLE) && !(in_mem_write && sb_full);
    assign accept   = in_valid && in_ready;
    assign push     = accept && in_mem_write;

    // Walk oldest to youngest so the last matching entry wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) && (sb_addr_q[head_q + PTR_W'(k)] == in_addr)) begin
                hit      = 1'b1;
                hit_data = sb_data_q[head_q + PTR_W'(k)];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        pop            = 1'b0;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = wb_reg_write_q;
        wb_reg_dest_d  = wb_reg_dest_q;
        wb_data_d      = wb_data_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = sb_addr_q[head_q];
                    mem_wdata = sb_data_q[head_q];
                    pop       = mem_gnt;
                end
                if (accept) begin
                    if (in_mem_read && !hit) begin
                        state_d = LOAD_REQ;
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_reg_dest_d  = in_reg_dest;
                        wb_reg_write_d = in_mem_write ? 1'b0 : in_reg_write;
                        if (!in_mem_write) begin
                            wb_data_d = in_mem_read ? hit_data : in_alu_result;
                        end
                    end
                end
            end
            LOAD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = ld_addr_q;
                if (mem_gnt) begin
                    state_d = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (mem_rvalid) begin
                    state_d        = IDLE;
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = rw_q;
                    wb_reg_dest_d  = rd_q;
                    wb_data_d      = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            rw_q           <= 1'b0;
            rd_q           <= '0;
            ld_addr_q      <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_reg_dest_q  <= '0;
            wb_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_reg_dest_q  <= wb_reg_dest_d;
            wb_data_q      <= wb_data_d;
            if (accept) begin
                rw_q      <= in_reg_write;
                rd_q      <= in_reg_dest;
                ld_addr_q <= in_addr;
            end
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage carries no reset; validity is tracked by head/count alone.
    always_ff @(posedge clock) begin
        if (push) begin
            sb_addr_q[tail_q] <= in_addr;
            sb_data_q[tail_q] <= in_store_data;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_reg_dest  = wb_reg_dest_q;
    assign wb_data      = wb_data_q;
    assign fw_rd        = rd_q;
    assign fw_reg_write = rw_q;
    assign sb_empty     = (count_q == '0);

endmodule

// File: tb/tb_cpu_commit_stbuf.sv
// Randomized bench for cpu_commit_stbuf against an architectural memory model plus a simple memory responder.
module tb_cpu_commit_stbuf;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int D  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid, in_ready, in_reg_write, in_mem_read, in_mem_write;
    logic [RW-1:0] in_reg_dest;
    logic [DW-1:0] in_alu_result, in_store_data;
    logic          wb_valid, wb_reg_write;
    logic [RW-1:0] wb_reg_dest, fw_rd;
    logic [DW-1:0] wb_data;
    logic          fw_reg_write, mem_req, mem_we, mem_gnt, mem_rvalid, sb_empty;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clock = ~clock;

    cpu_commit_stbuf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW), .SB_DEPTH(D)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg_write(in_reg_write),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_reg_dest(in_reg_dest),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_reg_dest(wb_reg_dest), .wb_data(wb_data),
        .fw_rd(fw_rd), .fw_reg_write(fw_reg_write),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .sb_empty(sb_empty)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } st_t;

    st_t           sq[$];                   // stores accepted but not yet written to memory
    logic [DW-1:0] arch [logic [AW-1:0]];   // program-order view of memory
    logic [DW-1:0] bmem [logic [AW-1:0]];   // what the memory actually holds

    int checks = 0;
    int errors = 0;

    bit            busy, granted;
    int            rv_delay;
    logic [AW-1:0] ld_addr;
    logic          ld_rw;
    logic [RW-1:0] ld_rd;
    logic [DW-1:0] ld_exp;
    bit            exp_wb, exp_is_store;
    logic          exp_rw, exp_fw_rw;
    logic [RW-1:0] exp_rd, exp_fw_rd;
    logic [DW-1:0] exp_dat;
    int            gnt_pct;

    logic          t_valid, t_rw, t_ld, t_st;
    logic [RW-1:0] t_rd;
    logic [DW-1:0] t_alu, t_sd;

    logic [AW-1:0] atab [6] = '{32'h10, 32'h14, 32'h18, 32'h100, 32'h200, 32'h204};

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: entered and left at a negedge.
    task automatic step();
        bit            rdy_exp, acc, hit, exp_req, exp_we, gnt;
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        check_eq("wb_valid", wb_valid, exp_wb);
        if (exp_wb) begin
            check_eq("wb_reg_write", wb_reg_write, exp_rw);
            if (!exp_is_store) begin
                check_eq("wb_reg_dest", wb_reg_dest, exp_rd);
                check_eq("wb_data", wb_data, exp_dat);
            end
        end
        check_eq("fw_rd", fw_rd, exp_fw_rd);
        check_eq("fw_reg_write", fw_reg_write, exp_fw_rw);
        check_eq("sb_empty", sb_empty, sq.size() == 0);

        exp_req = busy ? !granted : (sq.size() > 0);
        exp_we  = !busy;
        gnt     = exp_req && ($urandom_range(99) < gnt_pct);
        in_valid      = t_valid;
        in_reg_write  = t_rw;
        in_mem_read   = t_ld;
        in_mem_write  = t_st;
        in_reg_dest   = t_rd;
        in_alu_result = t_alu;
        in_store_data = t_sd;
        mem_gnt       = gnt;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        if (busy && granted) begin
            if (rv_delay == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = bmem.exists(ld_addr) ? bmem[ld_addr] : dflt(ld_addr);
            end else begin
                rv_delay--;
            end
        end
        #1;
        rdy_exp = !busy && !(t_st && sq.size() == D);
        check_eq("in_ready", in_ready, rdy_exp);
        check_eq("mem_req", mem_req, exp_req);
        if (exp_req) begin
            check_eq("mem_we", mem_we, exp_we);
            check_eq("mem_addr", mem_addr, busy ? ld_addr : sq[0].a);
            if (exp_we) check_eq("mem_wdata", mem_wdata, sq[0].d);
        end

        acc    = t_valid && rdy_exp;
        exp_wb = 0;
        if (acc) begin
            a         = t_alu[AW-1:0];
            exp_fw_rw = t_rw;
            exp_fw_rd = t_rd;
            if (t_st) begin
                arch[a]      = t_sd;
                exp_wb       = 1;
                exp_is_store = 1;
                exp_rw       = 0;
            end else begin
                exp_is_store = 0;
                exp_rw       = t_rw;
                exp_rd       = t_rd;
                if (t_ld) begin
                    v   = arch.exists(a) ? arch[a] : dflt(a);
                    hit = 0;
                    foreach (sq[i]) if (sq[i].a == a) hit = 1;
                    if (hit) begin
                        exp_wb  = 1;
                        exp_dat = v;
                    end else begin
                        busy    = 1;
                        granted = 0;
                        ld_addr = a;
                        ld_rw   = t_rw;
                        ld_rd   = t_rd;
                        ld_exp  = v;
                    end
                end else begin
                    exp_wb  = 1;
                    exp_dat = t_alu;
                end
            end
        end
        if (gnt) begin
            if (exp_we) begin
                bmem[sq[0].a] = sq[0].d;
                void'(sq.pop_front());
            end else begin
                granted  = 1;
                rv_delay = $urandom_range(3);
            end
        end
        if (acc && t_st) sq.push_back('{a: t_alu[AW-1:0], d: t_sd});
        if (mem_rvalid) begin
            busy         = 0;
            exp_wb       = 1;
            exp_is_store = 0;
            exp_rw       = ld_rw;
            exp_rd       = ld_rd;
            exp_dat      = ld_exp;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic instr(input logic v, input int kind, input logic rw, input logic [RW-1:0] rd,
                         input logic [DW-1:0] alu, input logic [DW-1:0] sd);
        t_valid = v;
        t_ld    = (kind == 1);
        t_st    = (kind == 2);
        t_rw    = rw;
        t_rd    = rd;
        t_alu   = alu;
        t_sd    = sd;
        step();
    endtask

    task automatic drain_all();
        gnt_pct = 100;
        t_valid = 0;
        for (int i = 0; i < 40 && (sq.size() > 0 || busy); i++) step();
        check_eq("drain_done", (sq.size() == 0 && !busy), 1);
    endtask

    initial begin
        {in_valid, in_reg_write, in_mem_read, in_mem_write, mem_gnt, mem_rvalid} = '0;
        in_reg_dest = '0; in_alu_result = '0; in_store_data = '0; mem_rdata = '0;
        {t_valid, t_rw, t_ld, t_st} = '0;
        t_rd = '0; t_alu = '0; t_sd = '0;
        busy = 0; granted = 0; rv_delay = 0; exp_wb = 0; exp_is_store = 0;
        exp_rw = 0; exp_rd = '0; exp_dat = '0; exp_fw_rw = 0; exp_fw_rd = '0;
        gnt_pct = 0;

        repeat (2) @(negedge clock);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_sb_empty", sb_empty, 1);
        check_eq("rst_fw_rd", fw_rd, 0);
        check_eq("rst_wb_data", wb_data, 0);
        reset = 1'b1;
        @(negedge clock);

        // ALU writeback and forwarding
        instr(1, 0, 1, 5, 32'h1234, 0);
        instr(0, 0, 0, 0, 0, 0);

        // fill the buffer with memory stalled, then refuse a 5th store
        for (int i = 0; i < 4; i++) instr(1, 2, 0, 1, 32'h40 + 4 * i, 32'h50 + i);
        instr(1, 2, 0, 1, 32'h60, 32'h77);
        instr(1, 0, 1, 7, 32'h99, 0);
        gnt_pct = 100;
        instr(1, 2, 0, 1, 32'h60, 32'h77);
        gnt_pct = 0;
        instr(1, 2, 0, 1, 32'h60, 32'h77);
        drain_all();

        // youngest-match forwarding
        gnt_pct = 0;
        instr(1, 2, 0, 0, 32'h100, 32'hA);
        instr(1, 2, 0, 0, 32'h100, 32'hB);
        instr(1, 1, 1, 3, 32'h100, 0);
        instr(0, 0, 0, 0, 0, 0);
        drain_all();

        // randomized traffic
        gnt_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            instr($urandom_range(99) < 70, $urandom_range(2), $urandom_range(1),
                  RW'($urandom_range(31)), ($urandom_range(9) == 0) ? $urandom : atab[$urandom_range(5)],
                  $urandom);
        end
        drain_all();

        // reset while a load is in LOAD_WAIT, then a stray rvalid
        instr(1, 1, 1, 9, 32'h300, 0);
        instr(0, 0, 0, 0, 0, 0);
        check_eq("load_granted", granted, 1);
        rv_delay = 1000;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_wb_valid", wb_valid, 0);
        check_eq("mid_rst_in_ready", in_ready, 0);
        check_eq("mid_rst_mem_req", mem_req, 0);
        check_eq("mid_rst_sb_empty", sb_empty, 1);
        check_eq("mid_rst_fw_reg_write", fw_reg_write, 0);
        check_eq("mid_rst_wb_dest", wb_reg_dest, 0);
        sq.delete();
        busy = 0; granted = 0; exp_wb = 0; exp_fw_rw = 0; exp_fw_rd = '0;
        @(negedge clock);
        reset = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE;
        @(negedge clock);
        mem_rvalid = 1'b0;
        check_eq("post_rst_wb_valid", wb_valid, 0);
        check_eq("post_rst_in_ready", in_ready, 1);
        check_eq("post_rst_mem_req", mem_req, 0);
        instr(1, 0, 1, 2, 32'h55, 0);
        instr(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_commit_stbuf.md
Name: cpu_commit_stbuf

Overview:
Parametrised commit/memory stage between execute and writeback. Registers one instruction per cycle, writes ALU results back, and runs memory logic. Stores queue in an in-order store buffer that drains to data memory. Loads are served from the buffer (youngest match) or from data memory over a req/gnt/rvalid handshake.

Parameters:
DATA_WIDTH, 32, data/result width
ADDR_WIDTH, 32, memory address width (word addresses, full-width compare)
REG_ADDR_WIDTH, 5, register index width
SB_DEPTH, 4, store buffer entries (power of 2, >=2)

Ports:
clock  in  1  clock
reset  in  1  async active-low reset (0 = reset)
in_valid  in  1  instruction offered by execute
in_ready  out  1  stage accepts this cycle
in_reg_write  in  1  instruction writes a register
in_mem_read  in  1  load
in_mem_write  in  1  store (exclusive with in_mem_read)
in_reg_dest  in  REG_ADDR_WIDTH  destination register
in_alu_result  in  DATA_WIDTH  ALU result / memory address (low ADDR_WIDTH bits)
in_store_data  in  DATA_WIDTH  store data
wb_valid  out  1  writeback strobe
wb_reg_write  out  1  register write enable
wb_reg_dest  out  REG_ADDR_WIDTH  writeback register
wb_data  out  DATA_WIDTH  writeback data
fw_rd  out  REG_ADDR_WIDTH  forwarding: rd held in the stage
fw_reg_write  out  1  forwarding: held instruction writes rd
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  request address
mem_wdata  out  DATA_WIDTH  write data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_WIDTH  read data
sb_empty  out  1  store buffer empty (fence support)

Behaviour:
- Reset (reset=0, async): all outputs 0 except sb_empty=1; state IDLE; sb_count, head and tail pointers 0. Buffer contents lost; an outstanding memory transaction is abandoned; any mem_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, LOAD_REQ, LOAD_WAIT.
- in_ready = (state==IDLE) && !(in_mem_write && sb_count==SB_DEPTH). It is combinational on in_mem_write. There is no full-buffer bypass: a store is refused when full even if a pop occurs the same cycle.
- Accept = in_valid && in_ready. On each accept the stage register latches reg_write and reg_dest. fw_rd/fw_reg_write come from that register and stay valid through LOAD_REQ/LOAD_WAIT until writeback.
- Non-memory instruction: wb_valid=1 one cycle after accept, with wb_data=in_alu_result and wb_reg_write/wb_reg_dest as latched.
- Store: enqueue (addr, data) at tail and increment sb_count. wb_valid pulses one cycle later with wb_reg_write=0.
- Load, buffer hit: compare the address against all valid entries and use the youngest match. wb_valid one cycle later with that entry's data. No memory read is issued.
- Load, buffer miss: go to LOAD_REQ and drive mem_req=1, mem_we=0, mem_addr held stable until mem_gnt. On gnt go to LOAD_WAIT. On mem_rvalid, return to IDLE and pulse wb_valid=1 next cycle with wb_data=mem_rdata. A gnt and rvalid in the same cycle are not allowed (rvalid comes at least 1 cycle after gnt).
- Drain: only in IDLE with sb_count>0, drive mem_req=1, mem_we=1, with head addr/data. On mem_gnt, pop head and decrement sb_count. A load miss takes priority: drain never starts while state!=IDLE. A drain request already waiting for gnt is withdrawn when a load miss is accepted, and the load request is issued the next cycle.
- Simultaneous store enqueue and drain pop: sb_count is unchanged and both pointers advance.
- Pointers wrap modulo SB_DEPTH. sb_count width is clog2(SB_DEPTH+1).
- wb_valid is a single-cycle pulse. wb_data/wb_reg_dest hold their value until the next writeback.
- sb_empty = (sb_count==0).

Test Plan:
- ALU op reg_write=1, rd=5, alu=0x1234 -> next cycle wb_valid=1, wb_reg_dest=5, wb_data=0x1234. fw_rd=5 and fw_reg_write=1 from the accept edge.
- 4 stores with mem_gnt=0 -> sb_count=4, in_ready=0 for a 5th store. An ALU op is still accepted. Raising gnt one cycle -> 1 pop, then the 5th store is accepted.
- Stores 0x100<=0xA, 0x100<=0xB, then load 0x100 -> wb_data=0xB one cycle after accept. No mem_req with mem_we=0 is issued.
- Load miss 0x200, gnt 2 cycles after request, rvalid 3 cycles later with 0xCAFE -> in_ready=0 throughout, no store drain in that window, wb_data=0xCAFE one cycle after rvalid.
- 3 stores to 0x10/0x14/0x18 with gnt every cycle -> writes issued in order, sb_empty=1 after the 3rd gnt.
- Reset pulse during LOAD_WAIT, followed by mem_rvalid -> all outputs at reset values, no wb_valid, state IDLE.
